// File: rtl/rv_regfile.sv
// rv_regfile: RV32I integer register file with WB->ID write-through bypass, pending-write
// scoreboard and an optional debug access port (enabled by RV_RF_DBG_PORT_EN).
module rv_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_wb_rf_wen,
    input  logic [4:0]      i_wb_rf_waddr,
    input  logic [XLEN-1:0] i_wb_rf_wdata,
    input  logic [4:0]      i_id_rs1_addr,
    input  logic [4:0]      i_id_rs2_addr,
    output logic [XLEN-1:0] o_id_rs1_rdata,
    output logic [XLEN-1:0] o_id_rs2_rdata,
    input  logic            i_id_rd_alloc,
    input  logic [4:0]      i_id_rd_addr,
    output logic            o_id_rs1_busy,
    output logic            o_id_rs2_busy,
    input  logic            i_dbg_req,
    input  logic            i_dbg_we,
    input  logic [4:0]      i_dbg_addr,
    input  logic [XLEN-1:0] i_dbg_wdata,
    output logic            o_dbg_ack,
    output logic [XLEN-1:0] o_dbg_rdata
);
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic            wb_we;
    logic            dbg_wr;

    function automatic logic valid_addr(input logic [4:0] a);
        return a != 5'd0 && int'(a) < NREG;
    endfunction

    function automatic logic wb_hits(input logic [4:0] a);
        return i_wb_rf_wen && i_wb_rf_waddr == a && valid_addr(a);
    endfunction

    function automatic logic [XLEN-1:0] read_reg(input logic [4:0] a);
        if (!valid_addr(a)) return '0;
        if (wb_hits(a)) return i_wb_rf_wdata;
        return regs_q[a];
    endfunction

    function automatic logic is_busy(input logic [4:0] a);
        return valid_addr(a) && busy_q[a] && !wb_hits(a);
    endfunction

    assign wb_we          = i_wb_rf_wen && valid_addr(i_wb_rf_waddr);
    assign o_id_rs1_rdata = read_reg(i_id_rs1_addr);
    assign o_id_rs2_rdata = read_reg(i_id_rs2_addr);
    assign o_id_rs1_busy  = is_busy(i_id_rs1_addr);
    assign o_id_rs2_busy  = is_busy(i_id_rs2_addr);

`ifdef RV_RF_DBG_PORT_EN
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK, S_DONE} dbg_state_e;
    dbg_state_e      state_q, state_d;
    logic [XLEN-1:0] dbg_rdata_q, dbg_rdata_d;
    logic            dbg_go;

    // WB owns the write port; a pending debug access simply waits it out.
    assign dbg_go = state_q == S_ACCESS && !i_wb_rf_wen;
    assign dbg_wr = dbg_go && i_dbg_we && valid_addr(i_dbg_addr);

    always_comb begin
        state_d     = state_q;
        dbg_rdata_d = dbg_rdata_q;
        case (state_q)
            S_IDLE:   state_d = i_dbg_req ? S_ACCESS : S_IDLE;
            S_ACCESS: begin
                if (dbg_go) begin
                    state_d     = S_ACK;
                    dbg_rdata_d = i_dbg_we ? dbg_rdata_q : read_reg(i_dbg_addr);
                end
            end
            S_ACK:    state_d = S_DONE;
            default:  state_d = i_dbg_req ? S_DONE : S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign o_dbg_ack   = state_q == S_ACK;
    assign o_dbg_rdata = dbg_rdata_q;
`else
    logic unused_dbg;
    assign unused_dbg  = ^{i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata};
    assign dbg_wr      = 1'b0;
    assign o_dbg_ack   = 1'b0;
    assign o_dbg_rdata = '0;
`endif

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wb_we) begin
            regs_d[i_wb_rf_waddr] = i_wb_rf_wdata;
            busy_d[i_wb_rf_waddr] = 1'b0;
        end
`ifdef RV_RF_DBG_PORT_EN
        if (dbg_wr) regs_d[i_dbg_addr] = i_dbg_wdata;
`endif
        // Set after clear: a younger producer issued this cycle keeps the register pending.
        if (i_id_rd_alloc && valid_addr(i_id_rd_addr)) busy_d[i_id_rd_addr] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end
endmodule
